hazard_control_unit: RTL



---
 rtl/hazard_control_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Per-cycle pipeline sequencer for the 5-stage core. It covers the hazards that
// forwarding cannot resolve: load-use, a branch operand still being produced in
// EX, taken-branch flush, and a multi-cycle mul/div occupying EX. Control
// outputs are combinational from state and inputs. A saturating counter
// records the number of pc_stall cycles.
module hazard_control_unit #(
  parameter int MULDIV_CYCLES = 4,
  parameter int REG_AW        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_op1,
  input  logic [REG_AW-1:0] id_op2,
  input  logic              id_uses_op1,
  input  logic              id_uses_op2,
  input  logic              id_is_branch,
  input  logic              id_is_muldiv,
  input  logic              branch_taken,
  input  logic [REG_AW-1:0] ex_op1,
  input  logic [1:0]        ex_regwrite,
  input  logic              ex_memread,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_bubble,
  output logic              ex_hold,
  output logic              exmem_bubble,
  output logic              ifid_flush,
  output logic              muldiv_start,
  output logic              busy,
  output logic [15:0]       stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    BR_WAIT = 2'b01,
    MD_BUSY = 2'b10
  } state_t;

  // The start cycle is one EX cycle and the final MD_BUSY cycle sees cnt==0,
  // so the counter is loaded with two less than the total occupancy.
  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 2);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nxt_s;
  logic [15:0] stall_cycles_r;

  logic exw_s;
  logic brh_s;
  logic luh_s;
  logic md_go_s;
  logic flush_req_s;

  logic pc_stall_s;
  logic ifid_stall_s;
  logic idex_bubble_s;
  logic ex_hold_s;
  logic exmem_bubble_s;
  logic ifid_flush_s;
  logic muldiv_start_s;

  // Hazard terms, all qualified by a real instruction sitting in ID.
  assign exw_s       = (ex_regwrite == 2'b11);
  assign brh_s       = id_valid && id_is_branch && exw_s && (ex_op1 == id_op1);
  assign luh_s       = id_valid && ex_memread && exw_s &&
                       ((id_uses_op1 && (id_op1 == ex_op1)) ||
                        (id_uses_op2 && (id_op2 == ex_op1)));
  assign md_go_s     = id_valid && id_is_muldiv;
  assign flush_req_s = id_valid && branch_taken;

  // Next-state and raw control decode; RUN checks hazards in priority order.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    pc_stall_s     = 1'b0;
    ifid_stall_s   = 1'b0;
    idex_bubble_s  = 1'b0;
    ex_hold_s      = 1'b0;
    exmem_bubble_s = 1'b0;
    ifid_flush_s   = 1'b0;
    muldiv_start_s = 1'b0;
    case (state_r)
      RUN: begin
        if (brh_s) begin
          pc_stall_s    = 1'b1;
          ifid_stall_s  = 1'b1;
          idex_bubble_s = 1'b1;
          // A load result arrives one cycle later than an ALU result.
          if (ex_memread) begin
            state_nxt_s = BR_WAIT;
          end else begin
            state_nxt_s = RUN;
          end
        end else if (luh_s) begin
          pc_stall_s    = 1'b1;
          ifid_stall_s  = 1'b1;
          idex_bubble_s = 1'b1;
        end else if (md_go_s) begin
          muldiv_start_s = 1'b1;
          cnt_nxt_s      = CNT_LOAD;
          state_nxt_s    = MD_BUSY;
        end else if (flush_req_s) begin
          ifid_flush_s = 1'b1;
        end else begin
          ifid_flush_s = 1'b0;
        end
      end
      BR_WAIT: begin
        pc_stall_s    = 1'b1;
        ifid_stall_s  = 1'b1;
        idex_bubble_s = 1'b1;
        state_nxt_s   = RUN;
      end
      MD_BUSY: begin
        pc_stall_s     = 1'b1;
        ifid_stall_s   = 1'b1;
        ex_hold_s      = 1'b1;
        exmem_bubble_s = 1'b1;
        if (cnt_r == 4'd0) begin
          state_nxt_s = RUN;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // While reset is asserted every control output is forced inactive.
  assign pc_stall     = rst_n & pc_stall_s;
  assign ifid_stall   = rst_n & ifid_stall_s;
  assign idex_bubble  = rst_n & idex_bubble_s;
  assign ex_hold      = rst_n & ex_hold_s;
  assign exmem_bubble = rst_n & exmem_bubble_s;
  assign ifid_flush   = rst_n & ifid_flush_s;
  assign muldiv_start = rst_n & muldiv_start_s;
  assign busy         = rst_n & (state_r != RUN);
  assign stall_cycles = stall_cycles_r;

  // State, occupancy counter and saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= RUN;
      cnt_r          <= 4'd0;
      stall_cycles_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (pc_stall_s && (stall_cycles_r != 16'hFFFF)) begin
        stall_cycles_r <= stall_cycles_r + 16'd1;
      end
    end
  end

endmodule
